// File: rtl/instr_fetch.sv
// Program RAM plus program counter and start/run/halt sequencer feeding the decoder.
// Jumps use the decoder's cnt_wr_en/literal_adr feedback with no delay slot.
module instr_fetch #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prog_wr_en,
  input  logic [PC_WIDTH-1:0]          prog_addr,
  input  logic [PROGRAM_DataWidth-1:0] prog_data,
  input  logic                         pc_clear,
  input  logic                         run,
  input  logic                         halt,
  input  logic                         cnt_wr_en,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         instr_valid,
  output logic                         running
);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d;
  logic                           valid_q, valid_d;
  logic                           running_q, running_d;
  logic [PC_WIDTH-1:0]            next_pc;
  logic [PC_WIDTH-1:0]            rd_addr;
  logic                           rd_en;
  logic                           wr_en;
  logic [PROGRAM_DataWidth-1:0]   rd_data_q;
  logic [PROGRAM_DataWidth-1:0]   mem [0:(2**PC_WIDTH)-1];

  assign next_pc = cnt_wr_en ? literal_adr : pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_en   = 1'b0;
    rd_addr = pc_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        wr_en = prog_wr_en;
        if (pc_clear) pc_d = '0;
        if (run) state_d = START;
      end
      START: begin
        if (halt) begin
          state_d = IDLE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = pc_q;
          state_d = RUN;
        end
      end
      RUN: begin
        pc_d = next_pc;
        if (halt) begin
          state_d = IDLE;
        end else begin
          // Read address is next_pc itself, so a taken jump costs no bubble.
          rd_en   = 1'b1;
          rd_addr = next_pc;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d   = (state_d == RUN);
    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      running_q <= running_d;
    end
  end

  // Memory and its read register carry no reset so program contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[prog_addr] <= prog_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // Forcing NOP whenever not valid also gives the immediate zero on async reset.
  assign instruction = valid_q ? rd_data_q : '0;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign running     = running_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: load, fetch, jump, wrap, halt/resume, ignored writes, async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_wr_en;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        pc_clear;
  logic        run;
  logic        halt;
  logic        cnt_wr_en;
  logic [7:0]  literal_adr;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic        instr_valid;
  logic        running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_wr_en  (prog_wr_en),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .pc_clear    (pc_clear),
    .run         (run),
    .halt        (halt),
    .cnt_wr_en   (cnt_wr_en),
    .literal_adr (literal_adr),
    .instruction (instruction),
    .pc          (pc),
    .instr_valid (instr_valid),
    .running     (running)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    prog_wr_en = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    step();
    prog_wr_en = 1'b0;
  endtask

  task automatic chk_run(input string tag, input logic [7:0] exp_pc, input logic [15:0] exp_ins);
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
    chk({tag, "_ins"}, {16'd0, instruction}, {16'd0, exp_ins});
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; prog_wr_en = 1'b0; prog_addr = '0; prog_data = '0;
    pc_clear = 1'b0; run = 1'b0; halt = 1'b0; cnt_wr_en = 1'b0; literal_adr = '0;
    step(); step();
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_ins", {16'd0, instruction}, 32'd0);
    chk("rst_vld", {31'd0, instr_valid}, 32'd0);
    chk("rst_run", {31'd0, running}, 32'd0);
    reset = 1'b0;
    step();

    // Program load in IDLE
    wr(8'h00, 16'h0A40); wr(8'h01, 16'h1B20); wr(8'h02, 16'h2010); wr(8'h03, 16'h4A50);
    wr(8'h04, 16'h803F); wr(8'h05, 16'h5A5A); wr(8'h3F, 16'h4A50); wr(8'h40, 16'h5555);
    wr(8'hFE, 16'h1111); wr(8'hFF, 16'h2222);
    chk("idle_ins", {16'd0, instruction}, 32'd0);

    // Start: run sampled at edge N, START during N+1, valid from N+2
    run = 1'b1;
    step();
    run = 1'b0;
    chk("start_run", {31'd0, running}, 32'd1);
    chk("start_vld", {31'd0, instr_valid}, 32'd0);
    chk("start_ins", {16'd0, instruction}, 32'd0);
    step(); chk_run("seq0", 8'h00, 16'h0A40);
    step(); chk_run("seq1", 8'h01, 16'h1B20);
    step(); chk_run("seq2", 8'h02, 16'h2010);
    step(); chk_run("seq3", 8'h03, 16'h4A50);
    step(); chk_run("seq4", 8'h04, 16'h803F);

    // Jump with no bubble
    cnt_wr_en = 1'b1; literal_adr = 8'h3F;
    step();
    cnt_wr_en = 1'b0;
    chk_run("jmp", 8'h3F, 16'h4A50);
    step(); chk_run("post_jmp", 8'h40, 16'h5555);

    // Write during RUN together with halt: write ignored, pc advances
    prog_wr_en = 1'b1; prog_addr = 8'h01; prog_data = 16'hFFFF; halt = 1'b1;
    step();
    prog_wr_en = 1'b0; halt = 1'b0;
    chk("halt1_run", {31'd0, running}, 32'd0);
    chk("halt1_pc", {24'd0, pc}, 32'h41);

    // cnt_wr_en is ignored outside RUN
    cnt_wr_en = 1'b1; literal_adr = 8'h77;
    step();
    cnt_wr_en = 1'b0;
    chk("idle_jmp_pc", {24'd0, pc}, 32'h41);

    // pc_clear and run together
    pc_clear = 1'b1; run = 1'b1;
    step();
    pc_clear = 1'b0; run = 1'b0;
    chk("clr_pc", {24'd0, pc}, 32'd0);
    step(); chk_run("r2_0", 8'h00, 16'h0A40);
    step(); chk_run("r2_1_nowr", 8'h01, 16'h1B20);
    step(); chk_run("r2_2", 8'h02, 16'h2010);

    // Halt at pc 2, no jump
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt2_run", {31'd0, running}, 32'd0);
    chk("halt2_vld", {31'd0, instr_valid}, 32'd0);
    chk("halt2_ins", {16'd0, instruction}, 32'd0);
    chk("halt2_pc", {24'd0, pc}, 32'h03);

    // Resume at mem[3]
    run = 1'b1;
    step();
    run = 1'b0;
    step(); chk_run("resume", 8'h03, 16'h4A50);

    // Halt at pc 3, rewrite mem[0], resume at pc 4
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt3_pc", {24'd0, pc}, 32'h04);
    wr(8'h00, 16'h3333);
    run = 1'b1;
    step();
    run = 1'b0;
    // halt in START returns to IDLE with pc unchanged
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("hstart_run", {31'd0, running}, 32'd0);
    chk("hstart_pc", {24'd0, pc}, 32'h04);
    chk("hstart_ins", {16'd0, instruction}, 32'd0);
    run = 1'b1;
    step();
    run = 1'b0;
    step(); chk_run("r4", 8'h04, 16'h803F);

    // Wrap-around via jump to FE
    cnt_wr_en = 1'b1; literal_adr = 8'hFE;
    step();
    cnt_wr_en = 1'b0;
    chk_run("wrapFE", 8'hFE, 16'h1111);
    step(); chk_run("wrapFF", 8'hFF, 16'h2222);
    step(); chk_run("wrap00", 8'h00, 16'h3333);
    step(); step(); step(); step();
    step(); chk_run("pc5", 8'h05, 16'h5A5A);

    // Async reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", {24'd0, pc}, 32'd0);
    chk("arst_ins", {16'd0, instruction}, 32'd0);
    chk("arst_vld", {31'd0, instr_valid}, 32'd0);
    chk("arst_run", {31'd0, running}, 32'd0);
    #1 reset = 1'b0;
    run = 1'b1;
    step();
    run = 1'b0;
    step(); chk_run("after_rst", 8'h00, 16'h3333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-memory and program-counter unit that produces the 16-bit instruction word consumed by `decoder`, i.e. the supplying end of the decoder's `instruction` / `cnt_wr_en` / `literal_adr` interface. It holds a 2^PC_WIDTH x 16 program RAM that is loadable while halted. It runs a start/run/halt state machine and presents one instruction per clock while running. It resolves GOTO and taken conditional branches through the decoder's `cnt_wr_en` / `literal_adr` feedback with no delay slot.

## Interface
Parameters:
- PC_WIDTH, 8, program counter and program address width; memory depth is 2^PC_WIDTH
- PROGRAM_DataWidth, 16, instruction word width

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state except memory contents
- prog_wr_en  in  1  program write strobe; honoured only in IDLE
- prog_addr  in  PC_WIDTH  program write address
- prog_data  in  PROGRAM_DataWidth  program write data
- pc_clear  in  1  in IDLE: pc <= 0
- run  in  1  start/resume request; honoured only in IDLE
- halt  in  1  stop request; honoured in START and RUN
- cnt_wr_en  in  1  from decoder: load pc with literal_adr (jump taken)
- literal_adr  in  PC_WIDTH  from decoder: jump target
- instruction  out  PROGRAM_DataWidth  current instruction to decoder (registered)
- pc  out  PC_WIDTH  address of the word on `instruction` while RUN; resume address while IDLE
- instr_valid  out  1  high only in RUN
- running  out  1  high in START and RUN

## Operation
- States: IDLE, START, RUN. Reset -> IDLE.
- IDLE:
  - prog_wr_en writes mem[prog_addr] <= prog_data at the edge.
  - pc_clear sets pc <= 0.
  - run -> START.
  - instruction is held at 16'h0000 (Op_NOP), so the decoder issues no writes.
  - If pc_clear and run are asserted together, both take effect.
- START (exactly 1 cycle):
  - Synchronous read: instruction <= mem[pc] -> RUN.
  - halt in START -> IDLE, pc unchanged, instruction stays 0.
- RUN, each cycle:
  - next_pc = cnt_wr_en ? literal_adr : pc + 1 (mod 2^PC_WIDTH; 8'hFF + 1 wraps to 8'h00).
  - pc <= next_pc; instruction <= mem[next_pc].
  - Memory read address is next_pc (combinational), so a taken jump presents the target word on the very next cycle: no bubble, no delay slot.
- halt in RUN:
  - The instruction presented in that cycle counts as executed.
  - pc <= next_pc, including a jump taken that cycle.
  - instruction <= 0, instr_valid <= 0, state -> IDLE.
  - A later run resumes at that pc.
- Priority:
  - reset > halt > everything else.
  - run in START/RUN is ignored. prog_wr_en outside IDLE is ignored, so memory is unchanged.
  - cnt_wr_en is ignored unless state is RUN.
- Memory is not cleared by reset; its contents survive reset.

## Timing
- Reset values: pc = 0, instruction = 16'h0000, instr_valid = 0, running = 0, state = IDLE.
- run sampled at edge N in IDLE:
  - START during cycle N+1.
  - instruction = mem[pc] and instr_valid = 1 from edge N+2.
- Write/run in the same IDLE cycle: the write lands at edge N and the START read happens at edge N+1, so the new word is fetched.
- Throughput: one instruction per clock in RUN.
- Jump: cnt_wr_en must be valid combinationally in the same cycle as its instruction. Target word appears 1 edge later.
- halt at edge M: instr_valid = 0, instruction = 0, running = 0 from edge M.
- Asynchronous reset mid-RUN: all outputs go to reset values immediately, without waiting for a clock edge. Memory keeps its contents.

## Test plan
- Load and sequential fetch:
  - Stimulus: in IDLE write mem[0..3] = 16'h0A40, 16'h1B20, 16'h2010, 16'h4A50; pulse run.
  - Response: instr_valid rises 2 cycles after run; instruction walks 0A40, 1B20, 2010, 4A50 with pc 0..3, one per cycle.
- Jump, no bubble:
  - Stimulus: mem[4] = GOTO 8'h3F (16'h803F), mem[8'h3F] = 16'h4A50; force cnt_wr_en = 1, literal_adr = 8'h3F while pc = 4.
  - Response: the next cycle shows pc = 8'h3F and instruction = 16'h4A50.
- Wrap-around:
  - Stimulus: pc_clear=0, pc preset via jump to 8'hFE; mem[FE] = 16'h1111, mem[FF] = 16'h2222, mem[00] = 16'h3333.
  - Response: sequence 1111, 2222, 3333 with pc FE, FF, 00.
- Halt/resume:
  - Stimulus: halt while pc = 2 with no jump.
  - Response: running = 0, instruction = 0, pc = 3. Then run -> first valid instruction is mem[3].
- Writes ignored while running:
  - Stimulus: prog_wr_en, addr 1, data 16'hFFFF in RUN; then halt, pc_clear, run.
  - Response: mem[1] still holds its old value when fetched.
- Async reset mid-RUN:
  - Stimulus: assert reset between clock edges at pc = 5.
  - Response: pc = 0, instruction = 0, instr_valid = 0, running = 0 immediately. After release and run, mem[0] is fetched with its old contents.
